bram_block_reader: RTL and testbench



---
 rtl/bram_block_reader_if.sv | 26 ++
 rtl/bram_block_reader.sv | 81 ++++++++
 tb/tb_bram_block_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bram_block_reader_if.sv
// bram_block_reader_if: command, RAM read port and output stream of bram_block_reader
interface bram_block_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  modport master (
    input  start, base_addr, len, mem_dout, m_ready,
    output busy, done, mem_we, mem_addr, m_valid, m_data, m_last
  );
  modport slave (
    output start, base_addr, len, mem_dout, m_ready,
    input  busy, done, mem_we, mem_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/bram_block_reader.sv
// bram_block_reader: streams a wrapping block of BRAM words onto a valid/ready stream
module bram_block_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input logic clk,
  input logic rst,
  bram_block_reader_if.master bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, v1_q, v1_d, v2_q, v2_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d, cur;
  logic [ADDR_W:0]   issue_q, issue_d, deliver_q, deliver_d;
  logic [DATA_W-1:0] fifo_q [4];
  logic [DATA_W-1:0] fifo_d [4];
  logic [1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [2:0]        cnt_q, cnt_d, used;
  logic              accept, issue, push, pop, last;
  // The first read goes out on the accepting edge itself so data lands in the FIFO two edges later.
  always_comb begin
    accept     = state_q == IDLE && bus.start;
    used       = cnt_q + 3'(v1_q) + 3'(v2_q);
    issue      = accept ? bus.len != '0 : state_q == RUN && issue_q != '0 && used < 3'd4;
    cur        = accept ? bus.base_addr : addr_q;
    push       = v2_q;
    pop        = cnt_q != '0 && bus.m_ready;
    last       = pop && deliver_q == (ADDR_W+1)'(1);
    mem_addr_d = issue ? cur : mem_addr_q;
    addr_d     = issue ? cur + ADDR_W'(1) : addr_q;
    issue_d    = issue ? (accept ? bus.len : issue_q) - (ADDR_W+1)'(1) : issue_q;
    deliver_d  = accept ? bus.len : deliver_q - (ADDR_W+1)'(pop);
    state_d    = accept && bus.len != '0 ? RUN : last ? IDLE : state_q;
    busy_d     = state_d == RUN;
    done_d     = (accept && bus.len == '0) || last;
    v1_d       = issue;
    v2_d       = v1_q;
    for (int i = 0; i < 4; i++) fifo_d[i] = push && wr_q == 2'(i) ? bus.mem_dout : fifo_q[i];
    wr_d       = wr_q + 2'(push);
    rd_d       = rd_q + 2'(pop);
    cnt_d      = cnt_q + 3'(push) - 3'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      issue_q    <= '0;
      deliver_q  <= '0;
      fifo_q     <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      issue_q    <= issue_d;
      deliver_q  <= deliver_d;
      fifo_q     <= fifo_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mem_we   = 1'b0;
  assign bus.mem_addr = mem_addr_q;
  assign bus.m_valid  = cnt_q != '0;
  assign bus.m_data   = fifo_q[rd_q];
  assign bus.m_last   = cnt_q != '0 && deliver_q == (ADDR_W+1)'(1);
endmodule

// File: tb/tb_bram_block_reader.sv
// tb_bram_block_reader: directed self-checking bench for bram_block_reader with a registered RAM model
module tb_bram_block_reader;
  logic clk, rst;
  logic [15:0] ram [1024];
  logic [15:0] got [$];
  int addrs [$];
  int total = 0, bad = 0;
  int first_v, last_c, done_c, nlast, max_out, unstable, we_hi;
  bram_block_reader_if #(.ADDR_W(10), .DATA_W(16)) bus ();
  bram_block_reader #(.ADDR_W(10), .DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) bus.mem_dout <= ram[bus.mem_addr];
  function automatic logic [15:0] ev(input int a);
    return 16'(a % 1024) ^ 16'hA5A5;
  endfunction
  // Runs one transfer from the cycle start is driven; c counts negedges from that cycle.
  task automatic run(input logic [9:0] b, input logic [10:0] l, input bit bp,
                     input int rs_c, input logic [9:0] rs_b, input logic [10:0] rs_l);
    logic [31:0] pat;
    logic seen, stall;
    logic [9:0] pa;
    logic [15:0] pd;
    int issued;
    pat = 32'hB6D9_A5F3;
    seen = 1'b0; stall = 1'b0; pa = '0; pd = '0; issued = 0;
    got.delete(); addrs.delete();
    first_v = -1; last_c = -1; done_c = -1; nlast = 0; max_out = 0; unstable = 0; we_hi = 0;
    for (int c = 0; c < 1200 + int'(l); c++) begin
      @(negedge clk);
      bus.start = c == 0 || c == rs_c;
      bus.base_addr = c == 0 ? b : rs_b;
      bus.len = c == 0 ? l : rs_l;
      bus.m_ready = !bp || (!(c >= 4 && c < 14) && pat[c % 32]);
      if (bus.mem_we !== 1'b0) we_hi++;
      if (bus.busy && !seen) begin
        seen = 1'b1; issued = 1; addrs.push_back(int'(bus.mem_addr));
      end else if (seen && bus.mem_addr !== pa) begin
        issued++; addrs.push_back(int'(bus.mem_addr));
      end
      pa = bus.mem_addr;
      if (issued - got.size() > max_out) max_out = issued - got.size();
      if (stall && (bus.m_data !== pd || !bus.m_valid)) unstable++;
      if (bus.m_valid && first_v < 0) first_v = c;
      stall = bus.m_valid && !bus.m_ready;
      pd = bus.m_data;
      if (bus.m_valid && bus.m_ready) begin
        got.push_back(bus.m_data);
        if (bus.m_last) begin nlast++; last_c = c; end
      end
      if (bus.done) begin done_c = c; break; end
    end
    bus.start = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    total++; if (bus.mem_addr !== 10'd0) begin bad++; $display("FAIL reset_mem_addr: got %0d want 0", bus.mem_addr); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    total++; if (bus.m_data !== 16'd0) begin bad++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
    total++; if (bus.m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
    rst = 1'b0;
  endtask
  task automatic test_basic();
    int err;
    run(10'd5, 11'd4, 1'b0, -1, '0, '0);
    err = got.size() == 4 ? 0 : 1;
    foreach (got[i]) if (got[i] !== ev(5 + i)) err++;
    total++; if (err !== 0) begin bad++; $display("FAIL basic_words: got %0d bad words want 0 (n=%0d)", err, got.size()); end
    total++; if (first_v !== 3) begin bad++; $display("FAIL basic_first_valid: got %0d want 3", first_v); end
    total++; if (last_c !== 6) begin bad++; $display("FAIL basic_last_cycle: got %0d want 6", last_c); end
    total++; if (nlast !== 1) begin bad++; $display("FAIL basic_last_count: got %0d want 1", nlast); end
    total++; if (done_c !== 7) begin bad++; $display("FAIL basic_done_cycle: got %0d want 7", done_c); end
    total++; if (we_hi !== 0) begin bad++; $display("FAIL basic_mem_we: got %0d high cycles want 0", we_hi); end
  endtask
  task automatic test_wrap();
    int err;
    run(10'd1022, 11'd4, 1'b0, -1, '0, '0);
    err = addrs.size() == 4 && got.size() == 4 ? 0 : 1;
    foreach (addrs[i]) if (addrs[i] !== (1022 + i) % 1024) err++;
    foreach (got[i]) if (got[i] !== ev(1022 + i)) err++;
    total++; if (err !== 0) begin bad++; $display("FAIL wrap_order: got %0d errors want 0", err); end
    total++; if (done_c !== 7) begin bad++; $display("FAIL wrap_done_cycle: got %0d want 7", done_c); end
  endtask
  task automatic test_backpressure();
    int err;
    run(10'd300, 11'd16, 1'b1, -1, '0, '0);
    err = got.size() == 16 ? 0 : 1;
    foreach (got[i]) if (got[i] !== ev(300 + i)) err++;
    total++; if (err !== 0) begin bad++; $display("FAIL bp_words: got %0d errors want 0 (n=%0d)", err, got.size()); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
    total++; if (max_out !== 4) begin bad++; $display("FAIL bp_outstanding: got %0d want 4", max_out); end
    total++; if (nlast !== 1) begin bad++; $display("FAIL bp_last_count: got %0d want 1", nlast); end
    total++; if (done_c < 0) begin bad++; $display("FAIL bp_done: got %0d want >=0", done_c); end
  endtask
  task automatic test_len0();
    int nv;
    nv = 0;
    run(10'd40, 11'd0, 1'b0, -1, '0, '0);
    total++; if (done_c !== 1) begin bad++; $display("FAIL len0_done_cycle: got %0d want 1", done_c); end
    repeat (4) begin @(negedge clk); if (bus.m_valid || bus.busy) nv++; end
    if (first_v >= 0) nv++;
    total++; if (nv !== 0) begin bad++; $display("FAIL len0_no_valid: got %0d active cycles want 0", nv); end
  endtask
  task automatic test_full();
    int err;
    run(10'd0, 11'd1024, 1'b0, -1, '0, '0);
    err = got.size() == 1024 ? 0 : 1;
    foreach (got[i]) if (got[i] !== ev(i)) err++;
    total++; if (err !== 0) begin bad++; $display("FAIL full_words: got %0d errors want 0 (n=%0d)", err, got.size()); end
    total++; if (nlast !== 1) begin bad++; $display("FAIL full_last_count: got %0d want 1", nlast); end
    total++; if (done_c !== 1027) begin bad++; $display("FAIL full_done_cycle: got %0d want 1027", done_c); end
  endtask
  task automatic test_start_busy();
    int err, nb;
    nb = 0;
    run(10'd50, 11'd3, 1'b0, 2, 10'd900, 11'd5);
    err = got.size() == 3 && addrs.size() == 3 ? 0 : 1;
    foreach (got[i]) if (got[i] !== ev(50 + i)) err++;
    total++; if (err !== 0) begin bad++; $display("FAIL busy_start_words: got %0d errors want 0", err); end
    total++; if (done_c !== 6) begin bad++; $display("FAIL busy_start_done: got %0d want 6", done_c); end
    repeat (4) begin @(negedge clk); if (bus.busy || bus.m_valid) nb++; end
    total++; if (nb !== 0) begin bad++; $display("FAIL busy_start_idle: got %0d active cycles want 0", nb); end
  endtask
  task automatic test_abort();
    int nv, nd, err;
    nv = 0; nd = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 10'd200; bus.len = 11'd10; bus.m_ready = 1'b1;
    for (int c = 0; c < 20 && nv < 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.m_valid) nv++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (nv !== 3) begin bad++; $display("FAIL abort_reach: got %0d words want 3", nv); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL abort_m_valid: got %b want 0", bus.m_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    if (bus.done) nd++;
    repeat (5) begin @(negedge clk); if (bus.done || bus.m_valid) nd++; end
    total++; if (nd !== 0) begin bad++; $display("FAIL abort_no_done: got %0d cycles want 0", nd); end
    run(10'd0, 11'd2, 1'b0, -1, '0, '0);
    err = got.size() == 2 ? 0 : 1;
    foreach (got[i]) if (got[i] !== ev(i)) err++;
    total++; if (err !== 0) begin bad++; $display("FAIL abort_restart_words: got %0d errors want 0", err); end
    total++; if (done_c !== 5) begin bad++; $display("FAIL abort_restart_done: got %0d want 5", done_c); end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = ev(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_full();
    test_start_busy();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
